// File: rtl/keypad_scanner_if.sv
// Keypad pin/result bundle between the board keypad and the scanner.
// Ports: row (keypad rows, active low), col (column drive, one-hot-low),
//        key (accepted key code), key_valid (accept/repeat strobe), key_held (press level).
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int KW = $clog2(ROWS * COLS);

    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [KW-1:0]   key;
    logic            key_valid;
    logic            key_held;

    // master: the scanner itself; slave: keypad/board side and result consumer
    modport master (input row, output col, key, key_valid, key_held);
    modport slave  (output row, input col, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, 2-FF row sync, frame-level press/release debounce.
// Latency: press accepted DEBOUNCE frames after the first frame that sees it, +1 clk.
// Backpressure: none; key_valid is a 1-clk strobe the consumer must take when it fires.
//
// Ports: clk, rst (async, active high); kp (keypad_scanner_if.master): row in, col/key/key_valid/key_held out.
// Optional feature: define KEYPAD_REPEAT_EN to build the auto-repeat logic (REPEAT_DELAY/REPEAT_RATE).
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE     = 3,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scanner_if.master  kp
);
    localparam int KW  = $clog2(ROWS * COLS);
    localparam int CIW = $clog2(COLS);
    localparam int SW  = $clog2(SCAN_DIV);
    localparam int DW  = $clog2(DEBOUNCE + 1);

    if (ROWS < 2 || COLS < 2 || SCAN_DIV < 4 || DEBOUNCE < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    // ---------------- scan / sample path ----------------
    logic            run_q;
    logic [SW-1:0]   slot_q;
    logic [CIW-1:0]  col_idx_q;
    logic [ROWS-1:0] sync1_q, sync2_q;
    logic            best_vld_q;      // lowest code seen so far in this frame
    logic [KW-1:0]   best_q;
    logic            res_rdy_q;       // one-clk strobe: frame result just latched
    logic            res_vld_q;       // frame result is a key (else NONE)
    logic [KW-1:0]   res_q;

    logic            slot_end, frame_end, col_hit, take, merged_vld;
    logic [KW-1:0]   col_code, merged_code;

    assign slot_end  = run_q && (slot_q == SW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (col_idx_q == CIW'(COLS - 1));

    // Lowest low row in the current column; descending loop leaves the smallest r.
    always_comb begin
        col_hit  = 1'b0;
        col_code = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!sync2_q[r]) begin
                col_hit  = 1'b1;
                col_code = KW'(r * COLS) + KW'(col_idx_q);
            end
        end
    end

    // A later column can still hold a lower code (lower row), so compare.
    assign take        = col_hit && (!best_vld_q || (col_code < best_q));
    assign merged_vld  = best_vld_q || col_hit;
    assign merged_code = take ? col_code : best_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= 1'b0;
            slot_q     <= '0;
            col_idx_q  <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            best_vld_q <= 1'b0;
            best_q     <= '0;
            res_rdy_q  <= 1'b0;
            res_vld_q  <= 1'b0;
            res_q      <= '0;
        end else begin
            sync1_q   <= kp.row;
            sync2_q   <= sync1_q;
            run_q     <= 1'b1;
            res_rdy_q <= frame_end;
            if (run_q) begin
                if (slot_end) begin
                    slot_q    <= '0;
                    col_idx_q <= (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + CIW'(1);
                end else begin
                    slot_q <= slot_q + SW'(1);
                end
            end
            if (frame_end) begin
                res_vld_q  <= merged_vld;
                res_q      <= merged_code;
                best_vld_q <= 1'b0;
                best_q     <= '0;
            end else if (slot_end) begin
                best_vld_q <= merged_vld;
                best_q     <= merged_code;
            end
        end
    end

    assign kp.col = run_q ? ~(COLS'(1) << col_idx_q) : '1;

    // ---------------- debounce FSM ----------------
    state_t        state_q, state_d;
    logic [KW-1:0] cand_q, cand_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] key_q, key_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q, key_held_d;
    logic          is_key, is_cand, accept;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_armed_q, rep_armed_d;   // first repeat (REPEAT_DELAY) already issued
`endif

    assign is_key  = res_vld_q && (res_q == key_q);
    assign is_cand = res_vld_q && (res_q == cand_q);

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
`endif
        if (res_rdy_q) begin
            unique case (state_q)
                IDLE: begin
                    if (res_vld_q) begin
                        cand_d = res_q;
                        cnt_d  = DW'(1);
                        if (DEBOUNCE == 1) accept  = 1'b1;
                        else               state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (!res_vld_q) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (is_cand) begin
                        cnt_d = cnt_q + DW'(1);
                        if (cnt_q + DW'(1) == DW'(DEBOUNCE)) accept = 1'b1;
                    end else begin
                        cand_d = res_q;
                        cnt_d  = DW'(1);
                    end
                end
                PRESSED: begin
                    if (is_key) begin
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d = rep_cnt_q + RW'(1);
                        if (rep_cnt_q + RW'(1) ==
                            (rep_armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY))) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end
`endif
                    end else if (DEBOUNCE == 1) begin
                        key_held_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = DW'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (is_key) begin
                        state_d = PRESSED;
                    end else begin
                        cnt_d = cnt_q + DW'(1);
                        if (cnt_q + DW'(1) == DW'(DEBOUNCE)) begin
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                            state_d    = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (accept) begin
            key_d       = res_q;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            cnt_d       = '0;
            state_d     = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a physical keypad model drives rows from the pressed-key set,
// and a frame-level reference model predicts key_valid/key/key_held.
module tb_keypad_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int RDLY  = 4;
    localparam int RRATE = 2;
    localparam int NK    = ROWS * COLS;
    localparam int FRAME = COLS * SDIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    // reference model state (frame granularity)
    int m_cand = -1, m_run = 0, m_key = 0, m_rel = 0, m_pulses = 0;
    bit m_held = 1'b0, m_pulse = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    int m_rep = 0;
`endif
    int seen_pulses = 0;

    keypad_scanner_if #(.ROWS(ROWS), .COLS(COLS)) kp ();

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    always #5 clk = ~clk;

    // keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        kp.row = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!kp.col[c] && pressed[r*COLS+c]) kp.row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NK-1:0] kbit(input int k);
        logic [NK-1:0] b;
        b = '0;
        b[k] = 1'b1;
        return b;
    endfunction

    // frame result: lowest pressed code, -1 for none
    function automatic int frame_result(input logic [NK-1:0] m);
        for (int k = 0; k < NK; k++) if (m[k]) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_cand = -1; m_run = 0; m_key = 0; m_rel = 0;
        m_held = 1'b0; m_pulse = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        m_rep = 0;
`endif
    endtask

    task automatic model_step(input int res);
        m_pulse = 1'b0;
        if (!m_held) begin
            if (res < 0) begin
                m_cand = -1; m_run = 0;
            end else if (res == m_cand) begin
                m_run++;
            end else begin
                m_cand = res; m_run = 1;
            end
            if (m_run == DEB) begin
                m_key = res; m_held = 1'b1; m_pulse = 1'b1;
                m_rel = 0; m_cand = -1; m_run = 0;
`ifdef KEYPAD_REPEAT_EN
                m_rep = 0;
`endif
            end
        end else if (res == m_key) begin
`ifdef KEYPAD_REPEAT_EN
            if (m_rel == 0) begin
                m_rep++;
                if (m_rep >= RDLY && ((m_rep - RDLY) % RRATE) == 0) m_pulse = 1'b1;
            end
`endif
            m_rel = 0;
        end else begin
            m_rel++;
            if (m_rel == DEB) begin
                m_held = 1'b0; m_rel = 0;
            end
        end
        if (m_pulse) m_pulses++;
    endtask

    // Runs nclk clocks of a frame starting at the negedge after the frame-start edge.
    // Outputs produced by the previous frame end are visible on the first of these clocks.
    task automatic run_frame(input logic [NK-1:0] mask, input int nclk);
        logic [COLS-1:0] ec;
        pressed = mask;
        for (int i = 1; i <= nclk; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (kp.key_valid === 1'b1) seen_pulses++;
            ec = '1;
            ec[(i % FRAME) / SDIV] = 1'b0;
            check("col_scan", 32'(kp.col), 32'(ec));
            if (i == 1) begin
                check("key_valid", 32'(kp.key_valid), 32'(m_pulse));
                check("key", 32'(kp.key), m_key);
                check("key_held", 32'(kp.key_held), 32'(m_held));
            end else begin
                check("key_valid_width", 32'(kp.key_valid), 0);
            end
        end
        if (nclk == FRAME) model_step(frame_result(mask));
    endtask

    task automatic frames(input logic [NK-1:0] mask, input int n);
        for (int f = 0; f < n; f++) run_frame(mask, FRAME);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_col", 32'(kp.col), 32'hF);
        check("rst_key", 32'(kp.key), 0);
        check("rst_key_valid", 32'(kp.key_valid), 0);
        check("rst_key_held", 32'(kp.key_held), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_release_col", 32'(kp.col), 32'hF);
        @(negedge clk);
        model_reset();
    endtask

    initial begin
        int p0;
        logic [NK-1:0] rmask;

        apply_reset();

        // clean press of key 6 (row1/col2)
        p0 = seen_pulses;
        frames(kbit(6), 6);
        check("press_pulses", seen_pulses - p0, 1);
        check("press_key", 32'(kp.key), 6);
        check("press_held", 32'(kp.key_held), 1);

        // release: held drops after debounce, key retained
        frames('0, 4);
        check("release_key", 32'(kp.key), 6);
        check("release_held", 32'(kp.key_held), 0);

        // bouncing key never accepted
        p0 = seen_pulses;
        for (int b = 0; b < 5; b++) begin
            frames(kbit(6), 1);
            frames('0, 1);
        end
        check("bounce_pulses", seen_pulses - p0, 0);
        check("bounce_held", 32'(kp.key_held), 0);

        // two keys: code 3 (row0/col3) beats code 9 (row2/col1)
        p0 = seen_pulses;
        frames(kbit(3) | kbit(9), 5);
        check("twokey_pulses", seen_pulses - p0, 1);
        check("twokey_key", 32'(kp.key), 3);
        frames('0, 4);

        // key change while pressed: new key only after release debounce + press debounce
        p0 = seen_pulses;
        frames(kbit(6), 4);
        frames(kbit(10), 6);
        frames('0, 4);
        check("switch_pulses", seen_pulses - p0, 2);
        check("switch_key", 32'(kp.key), 10);

        // reset during press debounce (two frames seen)
        p0 = seen_pulses;
        frames(kbit(6), 2);
        run_frame(kbit(6), 8);
        check("prereset_pulses", seen_pulses - p0, 0);
        apply_reset();
        p0 = seen_pulses;
        frames(kbit(6), 4);
        check("postreset_pulses", seen_pulses - p0, 1);
        check("postreset_key", 32'(kp.key), 6);
        frames('0, 4);

        // long hold: auto-repeat only when built in
        p0 = seen_pulses;
        frames(kbit(6), 12);
        frames('0, 4);
`ifdef KEYPAD_REPEAT_EN
        check("hold_pulses", seen_pulses - p0, 4);
`else
        check("hold_pulses", seen_pulses - p0, 1);
`endif

        // randomized key activity against the reference model
        rmask = '0;
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0: rmask = '0;
                1: rmask = kbit($urandom_range(0, NK - 1));
                2: rmask = kbit($urandom_range(0, NK - 1)) | kbit($urandom_range(0, NK - 1));
                default: ;
            endcase
            frames(rmask, $urandom_range(1, 5));
        end
        frames('0, 4);
        check("total_pulses", seen_pulses, m_pulses);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
